// File: rtl/bp_lce_mem_arbiter_if.sv
// Request/response bundle between the two requesters, the memory port and the arbiter.
// slave is the arbiter's view and master is the environment's view.
interface bp_lce_mem_arbiter_if #(
  parameter int pkt_width_p = 64
);
  logic [pkt_width_p-1:0] cache_pkt_i;
  logic                   cache_v_i;
  logic                   cache_yumi_o;
  logic [pkt_width_p-1:0] lce_pkt_i;
  logic                   lce_v_i;
  logic                   lce_last_i;
  logic                   lce_yumi_o;
  logic [pkt_width_p-1:0] mem_pkt_o;
  logic                   mem_v_o;
  logic                   mem_ready_i;

  modport slave (
    input  cache_pkt_i, cache_v_i, lce_pkt_i, lce_v_i, lce_last_i, mem_ready_i,
    output cache_yumi_o, lce_yumi_o, mem_pkt_o, mem_v_o
  );

  modport master (
    output cache_pkt_i, cache_v_i, lce_pkt_i, lce_v_i, lce_last_i, mem_ready_i,
    input  cache_yumi_o, lce_yumi_o, mem_pkt_o, mem_v_o
  );
endinterface

// File: rtl/bp_lce_mem_arbiter.sv
// Two-requester arbiter for one cache memory port. The cache pipeline has default priority,
// the LCE is guaranteed progress by a starvation timer, and an LCE burst is kept atomic.
module bp_lce_mem_arbiter #(
  parameter int pkt_width_p         = 64,
  parameter int timeout_max_limit_p = 4,
  parameter int max_burst_p         = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  bp_lce_mem_arbiter_if.slave    bus,
  output logic                   data_sel_o,
  output logic                   lock_o,
  output logic                   burst_err_o
);

  localparam int timeout_w_lp = $clog2(timeout_max_limit_p + 1);
  localparam int beat_w_lp    = $clog2(max_burst_p + 1);
  localparam logic [timeout_w_lp-1:0] timeout_max_lp = timeout_w_lp'(timeout_max_limit_p);
  localparam logic [beat_w_lp-1:0]    beat_max_lp    = beat_w_lp'(max_burst_p);

  typedef enum logic [1:0] {
    e_idle    = 2'd0,
    e_starved = 2'd1,
    e_burst   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [timeout_w_lp-1:0] timeout_cnt_q, timeout_cnt_d;
  logic [beat_w_lp-1:0]    beat_cnt_q, beat_cnt_d;
  logic                    data_sel_q, data_sel_d;
  logic                    burst_err_q, burst_err_d;

  logic                    gnt_lce, gnt_cache;
  logic                    lce_yumi, cache_yumi;
  logic [pkt_width_p-1:0]  mem_pkt;

  // Outside e_idle the LCE owns priority; inside a burst the cache is locked out entirely.
  assign gnt_lce    = bus.lce_v_i & ((state_q != e_idle) | ~bus.cache_v_i);
  assign gnt_cache  = bus.cache_v_i & ~gnt_lce & (state_q != e_burst);
  assign lce_yumi   = gnt_lce & bus.mem_ready_i;
  assign cache_yumi = gnt_cache & bus.mem_ready_i;
  assign mem_pkt    = gnt_lce ? bus.lce_pkt_i : bus.cache_pkt_i;

  assign bus.mem_pkt_o    = mem_pkt;
  assign bus.mem_v_o      = gnt_lce | gnt_cache;
  assign bus.lce_yumi_o   = lce_yumi;
  assign bus.cache_yumi_o = cache_yumi;

  assign lock_o      = (state_q != e_idle) | (timeout_cnt_q == timeout_max_lp);
  assign data_sel_o  = data_sel_q;
  assign burst_err_o = burst_err_q;

  always_comb begin
    timeout_cnt_d = timeout_cnt_q;
    if (~bus.lce_v_i | lce_yumi) begin
      timeout_cnt_d = '0;
    end else if (timeout_cnt_q != timeout_max_lp) begin
      timeout_cnt_d = timeout_cnt_q + timeout_w_lp'(1);
    end
  end

  // The starve transition fires on the same edge the counter saturates, so the LCE
  // is granted in the very cycle lock_o first rises.
  always_comb begin
    state_d = state_q;
    case (state_q)
      e_idle: begin
        if (lce_yumi) begin
          state_d = bus.lce_last_i ? e_idle : e_burst;
        end else if (timeout_cnt_d == timeout_max_lp) begin
          state_d = e_starved;
        end
      end
      e_starved: begin
        if (lce_yumi) begin
          state_d = bus.lce_last_i ? e_idle : e_burst;
        end
      end
      e_burst: begin
        if (lce_yumi & bus.lce_last_i) begin
          state_d = e_idle;
        end
      end
      default: state_d = e_idle;
    endcase
  end

  // The beat that opens a burst is counted too, so the count equals non-last beats accepted.
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    burst_err_d = burst_err_q;
    data_sel_d  = data_sel_q;
    if (lce_yumi) begin
      if (bus.lce_last_i) begin
        beat_cnt_d = '0;
      end else if (beat_cnt_q != beat_max_lp) begin
        beat_cnt_d = beat_cnt_q + beat_w_lp'(1);
      end
    end
    if (beat_cnt_d == beat_max_lp) begin
      burst_err_d = 1'b1;
    end
    if (lce_yumi | cache_yumi) begin
      data_sel_d = lce_yumi;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= e_idle;
      timeout_cnt_q <= '0;
      beat_cnt_q    <= '0;
      data_sel_q    <= 1'b0;
      burst_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      timeout_cnt_q <= timeout_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      data_sel_q    <= data_sel_d;
      burst_err_q   <= burst_err_d;
    end
  end

  a_one_yumi : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(lce_yumi && cache_yumi));
  a_beat_bound : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    beat_cnt_q <= beat_max_lp);

endmodule
